// File: rtl/decoder_3to8_stream.sv
// decoder_3to8_stream: registered, handshaked 3-to-8 one-hot decoder with sweep sequencer
//   clk, rst           : clock, synchronous active-high reset
//   din/din_valid/din_ready    : 3-bit index input stream
//   en                 : decode enable, sampled with each accepted din beat
//   sweep              : single-cycle request to emit 8'h01..8'h80 as 8 beats
//   dout/dout_valid/dout_ready : 8-bit one-hot output stream, one register stage
//   busy               : high while sweeping
//   count              : delivered output beats, built only with DECODER_3TO8_STREAM_COUNT_EN
module decoder_3to8_stream #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             en,
    input  logic             sweep,
    output logic [7:0]       dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             busy,
    output logic [CNT_W-1:0] count
);
    typedef enum logic {IDLE, SWEEP} state_t;
    state_t      state_q, state_d;
    logic        pend_q, pend_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  dout_q, dout_d;
    logic        dv_q, dv_d;
    logic        adv, start, in_hs;
    assign adv        = !dv_q || dout_ready;
    assign start      = sweep || pend_q;
    assign din_ready  = !rst && state_q == IDLE && adv && !start;
    assign in_hs      = din_valid && din_ready;
    assign dout       = dout_q;
    assign dout_valid = dv_q;
    assign busy       = state_q == SWEEP;
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        idx_d   = idx_q;
        dout_d  = dout_q;
        dv_d    = dv_q && !dout_ready;
        if (state_q == IDLE) begin
            if (start && adv) begin
                state_d = SWEEP;
                pend_d  = 1'b0;
                dout_d  = 8'h01;
                dv_d    = 1'b1;
                idx_d   = 3'd1;
            end else if (start) begin
                pend_d = 1'b1;
            end else if (in_hs) begin
                dout_d = en ? 8'b1 << din : 8'h00;
                dv_d   = 1'b1;
            end
        end else if (adv) begin
            // idx wraps to 0 after 8'h80 is loaded, marking the end of the sweep
            if (idx_q == 3'd0) begin
                state_d = IDLE;
            end else begin
                dout_d = 8'b1 << idx_q;
                dv_d   = 1'b1;
                idx_d  = idx_q + 3'd1;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pend_q  <= 1'b0;
            idx_q   <= 3'd0;
            dout_q  <= 8'h00;
            dv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            idx_q   <= idx_d;
            dout_q  <= dout_d;
            dv_q    <= dv_d;
        end
    end
`ifdef DECODER_3TO8_STREAM_COUNT_EN
    logic [CNT_W-1:0] cnt_q;
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else if (dv_q && dout_ready) cnt_q <= cnt_q + CNT_W'(1);
    end
    assign count = cnt_q;
`else
    assign count = '0;
`endif
endmodule
